aes_stream_loader: RTL
======================

# aes_stream_loader

Byte-stream front end for `aes_encrypt`. It collects 16 plaintext bytes from a valid/ready byte stream into a 128-bit block and issues a one-cycle load to the core. It then waits for the core's valid, captures the 128-bit ciphertext, and streams it back out as 16 bytes on a second valid/ready port. It sits between the board-level data source (UART/button logic) and `aes_encrypt`, replacing the hard-wired plaintext.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum cycles to wait in WAIT for the core's valid. 0 disables the timeout.
- `clk` in 1: single clock; every flop is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 8: plaintext byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts a byte this cycle. Registered.
- `out_data` out 8: ciphertext byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: sink accepts a byte.
- `enc_pt` out 128: plaintext to the core. Byte 0 is in [127:120].
- `enc_load` out 1: one-cycle load strobe to the core.
- `enc_ct` in 128: ciphertext from the core. Byte 0 is in [127:120].
- `enc_valid` in 1: core result valid. Level signal; it may stay high across blocks.
- `busy` out 1: high in LOAD, WAIT and DRAIN.
- `err` out 1: sticky timeout flag.

## Operation
- States: IDLE, FILL, LOAD, WAIT, DRAIN.
- IDLE: entered only from reset; goes to FILL unconditionally on the next edge.
- Byte counter: 4 bits, shared by FILL and DRAIN, cleared on every state entry.
- FILL:
  - `in_ready`=1.
  - On `in_valid & in_ready`, shift `enc_pt` left by 8 and put `in_data` in [7:0]. The first accepted byte therefore ends up in [127:120].
  - The 16th accept (count 15) moves to LOAD.
  - `in_valid` low stalls indefinitely; the counter holds.
- LOAD:
  - `enc_load`=1 for exactly this cycle.
  - `enc_pt` is held stable from entry to LOAD until the first accept in the next FILL.
  - Goes to WAIT unconditionally.
- Valid edge detect:
  - `enc_valid_q` is `enc_valid` registered every cycle; reset value 0.
  - A result event is `enc_valid & ~enc_valid_q`, sampled in LOAD or WAIT.
  - A level left high from the previous block is ignored.
- WAIT:
  - On a result event, capture `enc_ct` into the output shift register and move to DRAIN.
  - A wait counter increments each WAIT cycle. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with no event: set `err`, discard the block, go to FILL.
- DRAIN:
  - `out_valid`=1 and `out_data` = shift register [127:120].
  - On `out_valid & out_ready`, shift left by 8 and increment the counter.
  - While `out_ready`=0, `out_data` and `out_valid` hold.
  - The 16th handshake goes to FILL.
- `in_ready` is 0 in every state except FILL. Bytes offered outside FILL are not consumed.
- `err` is cleared only by reset and does not block operation.
- A result event in FILL or DRAIN is ignored. `enc_ct` is sampled only at the capture edge.

## Timing
- Reset values: all outputs 0; `enc_pt` and the output register 0; state IDLE.
- `in_ready` rises on the 2nd rising edge after `rst_n` deasserts (IDLE → FILL).
- Reset mid-operation (any state): all outputs return to 0 asynchronously; any partial block or pending result is lost.
- Input side: the 16th accept at edge t gives `enc_load`=1 in cycle t+1 and `in_ready`=0 from t+1.
- Output side:
  - A result event seen at edge t puts `out_valid`=1 and byte 0 on `out_data` from t+1.
  - Throughput is 1 byte/cycle when `out_ready` is held high.
  - The last handshake at edge t gives `in_ready`=1 at t+1.
- Timeout: `err` rises exactly TIMEOUT_CYCLES cycles after entering WAIT, with FILL active at the same edge.
- Round trip with the core latency at L cycles after load and no stalls: 16 fill + 1 load + L + 16 drain cycles.

## Test plan
Bench core model: `enc_ct` = `enc_pt` ^ 128'hFF…FF; the model pulses `enc_valid` L=12 cycles after `enc_load`.

- **Basic round trip:** feed bytes 0x05..0x14 back-to-back → `enc_load` for one cycle with `enc_pt`=128'h05060708…14; output bytes 0xFA,0xF9,…,0xEB in order; `busy` low again after the 16th output.
- **Stalls:** random `in_valid` gaps and `out_ready` held low for 5 cycles mid-drain → identical bytes; `out_data` stable during the stall; no byte duplicated or dropped.
- **Stale valid:** `enc_valid` held high from the previous block, with the model dropping it for 1 cycle before the new pulse → capture only on the new rising edge; captured ct matches the new block.
- **Timeout:** TIMEOUT_CYCLES=20, model never asserts valid → `err`=1 exactly 20 cycles after WAIT entry; `in_ready`=1 the same cycle. The next block of 0x00s round-trips to 0xFF×16 and `err` stays 1.
- **Reset during DRAIN:** assert `rst_n`=0 after 7 output bytes → `out_valid`, `busy`, `err`, `enc_load` are 0 immediately. After release, `in_ready` rises on the 2nd edge and a fresh block round-trips correctly.
- **Back-to-back blocks:** two blocks with `out_ready`=1 → the second block's fill starts the cycle after the first's last output byte; both outputs are correct.

Source files
------------

// File: rtl/aes_stream_loader.sv
// Byte-stream front end for aes_encrypt: packs 16 input bytes into a block,
// loads the core, waits for its result and streams the ciphertext back out.
module aes_stream_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] enc_pt,
    output logic         enc_load,
    input  logic [127:0] enc_ct,
    input  logic         enc_valid,
    output logic         busy,
    output logic         err
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_BYTE = '1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LOAD,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [BLK_W-1:0]    r_pt;
    logic [BLK_W-1:0]    r_ct;
    logic                r_enc_valid_q;
    logic                r_evt_pend;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_enc_load;
    logic                r_busy;
    logic                r_err;

    logic                w_evt;
    logic                w_accept;
    logic                w_out_hs;
    logic                w_capture;
    logic                w_timeout;
    logic                w_last_byte;

    // Rising edge only, so a level left high by the previous block is ignored
    assign w_evt       = enc_valid & ~r_enc_valid_q;
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_out_hs     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: w_next_state = S_FILL;
            S_FILL: begin
                w_accept = in_valid & r_in_ready;
                if (w_accept && w_last_byte) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: w_next_state = S_WAIT;
            S_WAIT: begin
                // An edge seen during LOAD is remembered and honoured here
                if (w_evt || r_evt_pend) begin
                    w_capture    = 1'b1;
                    w_next_state = S_DRAIN;
                end else if (TO_EN && (r_wait_cnt == WAIT_LAST)) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_FILL;
                end
            end
            S_DRAIN: begin
                w_out_hs = r_out_valid & out_ready;
                if (w_out_hs && w_last_byte) begin
                    w_next_state = S_FILL;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_pt          <= '0;
            r_ct          <= '0;
            r_enc_valid_q <= 1'b0;
            r_evt_pend    <= 1'b0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_enc_load    <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_enc_valid_q <= enc_valid;
            r_evt_pend    <= (r_state == S_LOAD) && w_evt;

            if (w_next_state != r_state) begin
                r_byte_cnt <= '0;
            end else if (w_accept || w_out_hs) begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end

            r_wait_cnt <= ((r_state == S_WAIT) && (w_next_state == S_WAIT))
                        ? r_wait_cnt + WCNT_W'(1) : '0;

            if (w_accept) begin
                r_pt <= {r_pt[BLK_W-BYTE_W-1:0], in_data};
            end

            if (w_capture) begin
                r_ct <= enc_ct;
            end else if (w_out_hs) begin
                r_ct <= {r_ct[BLK_W-BYTE_W-1:0], BYTE_W'(0)};
            end

            // The first FILL cycle after reset keeps in_ready low
            r_in_ready  <= (w_next_state == S_FILL) && (r_state != S_IDLE);
            r_out_valid <= (w_next_state == S_DRAIN);
            r_enc_load  <= (w_next_state == S_LOAD);
            r_busy      <= (w_next_state inside {S_LOAD, S_WAIT, S_DRAIN});
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_ct[BLK_W-1 -: BYTE_W];
    assign out_valid = r_out_valid;
    assign enc_pt    = r_pt;
    assign enc_load  = r_enc_load;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
